// File: rtl/fifo_pkg.sv
// Shared FIFO sizing constants and pointer-compare helpers.
// Pointers carry one extra wrap bit above the address bits.
package fifo_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefDepth = 16;

    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Full: address bits match, wrap bits differ. aw is the address width.
    function automatic logic is_full(input logic [31:0] wp, input logic [31:0] rp,
                                     input int unsigned aw);
        logic [31:0] diff;
        logic [31:0] mask;
        diff = wp ^ rp;
        mask = (32'd1 << aw) - 32'd1;
        return ((diff & mask) == 32'd0) && (((diff >> aw) & 32'd1) == 32'd1);
    endfunction

    function automatic logic is_empty(input logic [31:0] wp, input logic [31:0] rp,
                                      input int unsigned aw);
        logic [31:0] mask;
        mask = (32'd1 << (aw + 1)) - 32'd1;
        return ((wp ^ rp) & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, combinational read.
// Storage is deliberately not reset.
module fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock register FIFO with registered flags, registered read data
// (1-cycle latency) and sticky overflow/underflow indicators.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = addr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);
    localparam logic [AW:0]   PtrOne = (AW + 1)'(1);
    localparam logic [CW-1:0] CntOne = CW'(1);

    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              empty_q, empty_d, full_q, full_d, af_q, af_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d, mem_rdata;
    logic              rd_valid_q, ovf_q, ovf_d, unf_q, unf_d;
    logic              wr_acc, rd_acc;

    always_comb begin
        rd_acc = rd_en & ~empty_q;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        wr_acc = wr_en & (~full_q | rd_acc);

        wr_ptr_d = wr_acc ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + PtrOne : rd_ptr_q;

        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase

        empty_d   = is_empty(32'(wr_ptr_d), 32'(rd_ptr_d), AW);
        full_d    = is_full(32'(wr_ptr_d), 32'(rd_ptr_d), AW);
        af_d      = 32'(count_d) >= AF_LEVEL;
        rd_data_d = rd_acc ? mem_rdata : rd_data_q;
        ovf_d     = ovf_q | (wr_en & full_q & ~rd_acc);
        unf_d     = unf_q | (rd_en & empty_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            af_q       <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            af_q       <= af_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_acc;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    assign full        = full_q;
    assign almost_full = af_q;
    assign empty       = empty_q;
    assign count       = count_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule
